// File: rtl/shifter_r_pipe.sv
// Pipelined right barrel shifter, logical or arithmetic.
// One register stage per shift-amount bit: stage k shifts by 2^k when shamt[k]
// is set. Each stage carries a valid bit, the partially shifted data, the
// original shamt, the arith flag, the fill bit and the request tag.
// A combinational ready chain lets empty stages absorb new data while the
// output is stalled, so bubbles collapse.
module shifter_r_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_arith,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  // Stage registers
  logic               valid_q [SHAMT_W];
  logic               valid_d [SHAMT_W];
  logic [WIDTH-1:0]   data_q  [SHAMT_W];
  logic [WIDTH-1:0]   data_d  [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_q [SHAMT_W];
  logic [SHAMT_W-1:0] shamt_d [SHAMT_W];
  logic               arith_q [SHAMT_W];
  logic               arith_d [SHAMT_W];
  logic               fill_q  [SHAMT_W];
  logic               fill_d  [SHAMT_W];
  logic [TAG_W-1:0]   tag_q   [SHAMT_W];
  logic [TAG_W-1:0]   tag_d   [SHAMT_W];

  // What each stage would load: the upstream stage (or the input port for S0)
  logic               src_valid [SHAMT_W];
  logic [WIDTH-1:0]   src_data  [SHAMT_W];
  logic [SHAMT_W-1:0] src_shamt [SHAMT_W];
  logic               src_arith [SHAMT_W];
  logic               src_fill  [SHAMT_W];
  logic [TAG_W-1:0]   src_tag   [SHAMT_W];
  logic [WIDTH-1:0]   shifted   [SHAMT_W];

  // ready_vec[k]: stage k may load this cycle
  logic [SHAMT_W-1:0] ready_vec;

  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      localparam int STEP = 1 << gi;

      if (gi == 0) begin : g_src_in
        assign src_valid[gi] = in_valid;
        assign src_data[gi]  = in_data;
        assign src_shamt[gi] = in_shamt;
        assign src_arith[gi] = in_arith;
        // Sign fill is decided once from the original operand
        assign src_fill[gi]  = in_arith & in_data[WIDTH-1];
        assign src_tag[gi]   = in_tag;
      end else begin : g_src_prev
        assign src_valid[gi] = valid_q[gi-1];
        assign src_data[gi]  = data_q[gi-1];
        assign src_shamt[gi] = shamt_q[gi-1];
        assign src_arith[gi] = arith_q[gi-1];
        assign src_fill[gi]  = fill_q[gi-1];
        assign src_tag[gi]   = tag_q[gi-1];
      end

      // Fixed shift of 2^gi, selected by this stage's shamt bit
      assign shifted[gi] = src_shamt[gi][gi]
                           ? {{STEP{src_fill[gi]}}, src_data[gi][WIDTH-1:STEP]}
                           : src_data[gi];
    end
  endgenerate

  // Ready chain from the output back to the input: a stage can load if it is empty or its successor can load
  always_comb begin
    logic rdy;
    ready_vec = '0;
    rdy = out_ready;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      rdy = ~valid_q[k] | rdy;
      ready_vec[k] = rdy;
    end
  end

  // Next-state: hold when blocked, otherwise take the upstream contents (payload only when valid)
  always_comb begin
    for (int k = 0; k < SHAMT_W; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      arith_d[k] = arith_q[k];
      fill_d[k]  = fill_q[k];
      tag_d[k]   = tag_q[k];
      if (ready_vec[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          data_d[k]  = shifted[k];
          shamt_d[k] = src_shamt[k];
          arith_d[k] = src_arith[k];
          fill_d[k]  = src_fill[k];
          tag_d[k]   = src_tag[k];
        end
      end
    end
  end

  // Stage registers with synchronous active-low clear; in-flight work is dropped on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SHAMT_W; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        arith_q[k] <= 1'b0;
        fill_q[k]  <= 1'b0;
        tag_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < SHAMT_W; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        arith_q[k] <= arith_d[k];
        fill_q[k]  <= fill_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

  assign in_ready  = ready_vec[0];
  assign out_valid = valid_q[SHAMT_W-1];
  assign out_data  = data_q[SHAMT_W-1];
  assign out_tag   = tag_q[SHAMT_W-1];

endmodule

// File: doc/shifter_r_pipe.md
Name: shifter_r_pipe

Overview:
- Pipelined right barrel shifter (logical or arithmetic): the right-shift counterpart to the team's combinational left logical shifter.
- One log2 stage per register slice; each stage applies a shift of 2^k when shamt bit k is set.
- Sits between the operand-issue logic and the writeback path; valid/ready handshakes on both sides.
- Carries a tag alongside the data so the consumer can match results to requests.

Parameters:
WIDTH, 32, data width; power of two, >= 4
SHAMT_W, $clog2(WIDTH), shift-amount width and number of pipeline stages (derived; must not be overridden)
TAG_W, 4, width of the pass-through request tag

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request this cycle
in_data  input  WIDTH  operand to shift
in_shamt  input  SHAMT_W  right-shift amount, 0..WIDTH-1
in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
in_tag  input  TAG_W  request tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  shifted result
out_tag  output  TAG_W  tag of the result

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): all stage valid bits are cleared and all data, tag and shamt registers go to 0. After reset, out_valid=0, out_data=0 and out_tag=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: in-flight requests are discarded, not completed. No output appears for them.
- Structure: SHAMT_W register stages S0..S(SHAMT_W-1). Each stage holds valid, data, remaining shamt bits, arith, fill bit and tag.
- Fill bit: captured at input as in_arith & in_data[WIDTH-1] and carried through all stages.
- Stage k: if its shamt bit k = 1, data_next = {k-fill replicated 2^k times, data[WIDTH-1:2^k]}; otherwise data passes unchanged.
- Output ports are driven directly from the last stage's registers.
- Handshake:
  - A transfer occurs on a cycle when valid & ready are both high.
  - Per stage: ready_k = ~valid_k | ready_(k+1). ready after the last stage = out_ready. in_ready = ready_0.
  - The ready chain is combinational. No combinational path from in_valid to in_ready.
  - A stage whose downstream is not ready holds its contents. Bubbles ahead of a stall collapse: an empty stage accepts new data even when the output is stalled.
- Latency: exactly SHAMT_W cycles from input acceptance to out_valid when the pipe is empty and out_ready=1. WIDTH=32 gives 5 cycles.
- Throughput: one result per cycle with out_ready held at 1.
- Ordering: results leave strictly in acceptance order. The tag is unchanged.
- Stability: while out_valid=1 and out_ready=0, out_data and out_tag hold stable.
- Full pipe: in_ready=0 when all stages are valid and out_ready=0.
- Simultaneous events: a full pipe with out_ready=1 accepts a new input in the same cycle that it retires the output.
- Boundary cases:
  - shamt=0 returns the data unchanged.
  - shamt=WIDTH-1 logical returns in_data[WIDTH-1].
  - shamt=WIDTH-1 arithmetic returns all bits = sign.
  - in_arith with a positive operand behaves identically to logical.
- Input data, shamt, arith and tag are sampled only on an accepted transfer. Values when in_valid=0 are ignored.

Test Plan:
- Logical shift: in_data=0x8000_0000, shamt=31, arith=0, tag=3 -> after 5 cycles out_data=0x0000_0001, out_tag=3. Also shamt=0 -> 0x8000_0000.
- Arithmetic shift: 0x8000_0000 >> 4 gives 0xF800_0000. 0x7FFF_FFF0 >> 4 gives 0x07FF_FFFF. 0xFFFF_FFFF >> 31 gives 0xFFFF_FFFF.
- Back-to-back throughput: 8 requests on consecutive cycles, out_ready=1, tags 0..7 -> out_valid high for 8 consecutive cycles starting at cycle 5, in order, each result matching a reference model.
- Backpressure:
  - Hold out_ready=0 while streaming inputs -> exactly 5 accepted, then in_ready=0.
  - out_data/out_tag stable throughout the stall.
  - Release -> all 5 drain in order with no loss or duplication.
- Bubble collapse: one request issued, out_ready=0, then 4 more requests spaced 2 cycles apart -> all accepted while stalled until the pipe is full.
- Reset mid-flight: 3 requests in flight, assert rst_n=0 for 1 cycle -> out_valid=0 and out_data=0 next cycle, no stale results emerge afterwards, in_ready=1.
